// File: rtl/vend_pkg.sv
// Shared types and constants for the vending transaction sequencer.
// Amounts are in cents throughout.
package vend_pkg;

  localparam int AMT_W  = 12;
  localparam int CODE_W = 8;

  localparam logic [AMT_W-1:0] COIN_5   = 12'd5;
  localparam logic [AMT_W-1:0] COIN_10  = 12'd10;
  localparam logic [AMT_W-1:0] COIN_25  = 12'd25;
  localparam logic [AMT_W-1:0] COIN_100 = 12'd100;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_PAY     = 3'd1,
    ST_LOOKUP  = 3'd2,
    ST_LK_WAIT = 3'd3,
    ST_CHECK   = 3'd4,
    ST_VEND    = 3'd5,
    ST_CHANGE  = 3'd6
  } state_e;

  typedef enum logic [1:0] {
    ACC_HOLD    = 2'd0,
    ACC_SUB     = 2'd1,
    ACC_RESTORE = 2'd2,
    ACC_CLEAR   = 2'd3
  } acc_op_e;

endpackage

// File: rtl/vend_sequencer_if.sv
// Keypad, coin, price-lookup, motor and change-dispenser signals of the sequencer.
// master = sequencer side, slave = machine/environment side.
interface vend_sequencer_if;
  import vend_pkg::*;

  logic [CODE_W-1:0] key_code;
  logic              key_valid;
  logic [AMT_W-1:0]  coin_value;
  logic              coin_valid;
  logic              cancel;
  logic [CODE_W-1:0] lk_code;
  logic              lk_req;
  logic              price_valid;
  logic              price_invalid;
  logic [AMT_W-1:0]  price;
  logic              coin_reject;
  logic              vend_go;
  logic              vend_done;
  logic              chg_valid;
  logic [AMT_W-1:0]  chg_amount;
  logic              chg_ack;
  logic [AMT_W-1:0]  credit;
  logic              err_code;
  logic              err_jam;
  logic              busy;

  modport master (
    input  key_code, key_valid, coin_value, coin_valid, cancel,
    input  price_valid, price_invalid, price, vend_done, chg_ack,
    output lk_code, lk_req, coin_reject, vend_go, chg_valid, chg_amount,
    output credit, err_code, err_jam, busy
  );

  modport slave (
    output key_code, key_valid, coin_value, coin_valid, cancel,
    output price_valid, price_invalid, price, vend_done, chg_ack,
    input  lk_code, lk_req, coin_reject, vend_go, chg_valid, chg_amount,
    input  credit, err_code, err_jam, busy
  );

endinterface

// File: rtl/vend_credit_acc.sv
// Credit register: coin accumulation with ceiling check, purchase subtract,
// jam restore and clear; generates the registered coin_reject pulse.
module vend_credit_acc
  import vend_pkg::*;
#(
  parameter logic [AMT_W-1:0] MAX_CREDIT = 12'd500
) (
  input  logic             clk,
  input  logic             reset,
  input  acc_op_e          op,
  input  logic [AMT_W-1:0] amount,
  input  logic             coin_valid,
  input  logic             coin_en,
  input  logic [AMT_W-1:0] coin_value,
  output logic             coin_fits,
  output logic             coin_reject,
  output logic [AMT_W-1:0] credit
);

  logic [AMT_W-1:0] credit_r;
  logic [AMT_W-1:0] credit_nxt_s;
  logic [AMT_W:0]   sum_s;
  logic             coin_accept_s;
  logic             coin_reject_r;

  // One extra bit so a large coin can never wrap past the ceiling.
  assign sum_s         = {1'b0, credit_r} + {1'b0, coin_value};
  assign coin_fits     = (sum_s <= {1'b0, MAX_CREDIT});
  assign coin_accept_s = coin_valid && coin_en && coin_fits && (op == ACC_HOLD);

  // Next credit value for the requested operation
  always_comb begin
    credit_nxt_s = credit_r;
    case (op)
      ACC_SUB:     credit_nxt_s = credit_r - amount;
      ACC_RESTORE: credit_nxt_s = credit_r + amount;
      ACC_CLEAR:   credit_nxt_s = {AMT_W{1'b0}};
      default: begin
        if (coin_accept_s) begin
          credit_nxt_s = sum_s[AMT_W-1:0];
        end else begin
          credit_nxt_s = credit_r;
        end
      end
    endcase
  end

  // Credit and reject-pulse registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      credit_r      <= {AMT_W{1'b0}};
      coin_reject_r <= 1'b0;
    end else begin
      credit_r      <= credit_nxt_s;
      coin_reject_r <= coin_valid && !coin_accept_s;
    end
  end

  assign credit      = credit_r;
  assign coin_reject = coin_reject_r;

endmodule

// File: rtl/vend_sequencer.sv
// Vending transaction sequencer: credit, price lookup, vend/jam and change handshakes.
// Optional PAY inactivity auto-cancel is compiled in with VEND_PAY_TIMEOUT_EN.
module vend_sequencer
  import vend_pkg::*;
#(
  parameter logic [AMT_W-1:0] MAX_CREDIT   = 12'd500,
  parameter logic [31:0]      TIMEOUT_CYC  = 32'd500_000_000,
  parameter logic [15:0]      VEND_MAX_CYC = 16'd50_000
) (
  input logic              clk,
  input logic              reset,
  vend_sequencer_if.master bus
);

  state_e            state_r, state_nxt_s;
  logic [CODE_W-1:0] lk_code_r, lk_code_nxt_s;
  logic [AMT_W-1:0]  chg_amount_r, chg_amount_nxt_s;
  logic [AMT_W-1:0]  price_r, price_nxt_s;
  logic [15:0]       vend_cnt_r;
  logic              lk_req_r, vend_go_r, chg_valid_r, busy_r;
  logic              err_code_r, err_code_nxt_s;
  logic              err_jam_r, err_jam_nxt_s;
  acc_op_e           acc_op_s;
  logic [AMT_W-1:0]  acc_amt_s;
  logic              coin_en_s, coin_fits_s, coin_reject_s;
  logic [AMT_W-1:0]  credit_s;
  logic              timeout_s, cancel_s;

`ifdef VEND_PAY_TIMEOUT_EN
  logic [31:0] pay_cnt_r;

  // Inactivity counter in PAY; any coin or key restarts it
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pay_cnt_r <= 32'd0;
    end else if ((state_r != ST_PAY) || bus.coin_valid || bus.key_valid) begin
      pay_cnt_r <= 32'd0;
    end else if (pay_cnt_r != TIMEOUT_CYC) begin
      pay_cnt_r <= pay_cnt_r + 32'd1;
    end else begin
      pay_cnt_r <= pay_cnt_r;
    end
  end

  assign timeout_s = (state_r == ST_PAY) && (pay_cnt_r == TIMEOUT_CYC);
`else
  logic unused_timeout_s;
  assign unused_timeout_s = ^TIMEOUT_CYC;
  assign timeout_s        = 1'b0;
`endif

  assign cancel_s = bus.cancel || timeout_s;

  vend_credit_acc #(.MAX_CREDIT(MAX_CREDIT)) u_acc (
    .clk        (clk),
    .reset      (reset),
    .op         (acc_op_s),
    .amount     (acc_amt_s),
    .coin_valid (bus.coin_valid),
    .coin_en    (coin_en_s),
    .coin_value (bus.coin_value),
    .coin_fits  (coin_fits_s),
    .coin_reject(coin_reject_s),
    .credit     (credit_s)
  );

  // Next-state and datapath control
  always_comb begin
    state_nxt_s      = state_r;
    lk_code_nxt_s    = lk_code_r;
    chg_amount_nxt_s = chg_amount_r;
    price_nxt_s      = price_r;
    err_code_nxt_s   = 1'b0;
    err_jam_nxt_s    = err_jam_r;
    acc_op_s         = ACC_HOLD;
    acc_amt_s        = price_r;
    coin_en_s        = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (cancel_s) begin
          state_nxt_s = ST_IDLE;
        end else if (bus.key_valid && !err_jam_r) begin
          lk_code_nxt_s = bus.key_code;
          state_nxt_s   = ST_LOOKUP;
        end else if (bus.coin_valid && !bus.key_valid) begin
          coin_en_s = !err_jam_r;
          if (!err_jam_r && coin_fits_s) begin
            state_nxt_s = ST_PAY;
          end else begin
            state_nxt_s = ST_IDLE;
          end
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_PAY: begin
        if (cancel_s) begin
          if (credit_s == {AMT_W{1'b0}}) begin
            state_nxt_s = ST_IDLE;
          end else begin
            chg_amount_nxt_s = credit_s;
            state_nxt_s      = ST_CHANGE;
          end
        end else if (bus.key_valid && !err_jam_r) begin
          lk_code_nxt_s = bus.key_code;
          state_nxt_s   = ST_LOOKUP;
        end else begin
          coin_en_s = !err_jam_r && !bus.key_valid;
        end
      end
      ST_LOOKUP:  state_nxt_s = ST_LK_WAIT;
      ST_LK_WAIT: state_nxt_s = ST_CHECK;
      ST_CHECK: begin
        if (bus.price_invalid) begin
          err_code_nxt_s = 1'b1;
          state_nxt_s    = (credit_s != {AMT_W{1'b0}}) ? ST_PAY : ST_IDLE;
        end else if (bus.price_valid && (credit_s >= bus.price)) begin
          acc_op_s    = ACC_SUB;
          acc_amt_s   = bus.price;
          price_nxt_s = bus.price;
          state_nxt_s = ST_VEND;
        end else if (bus.price_valid) begin
          state_nxt_s = ST_PAY;
        end else begin
          state_nxt_s = (credit_s != {AMT_W{1'b0}}) ? ST_PAY : ST_IDLE;
        end
      end
      ST_VEND: begin
        if (bus.vend_done) begin
          if (credit_s == {AMT_W{1'b0}}) begin
            state_nxt_s = ST_IDLE;
          end else begin
            chg_amount_nxt_s = credit_s;
            state_nxt_s      = ST_CHANGE;
          end
        end else if (vend_cnt_r == (VEND_MAX_CYC - 16'd1)) begin
          // Jam: hand the whole purchase price back along with any change.
          err_jam_nxt_s    = 1'b1;
          acc_op_s         = ACC_RESTORE;
          acc_amt_s        = price_r;
          chg_amount_nxt_s = credit_s + price_r;
          state_nxt_s      = ST_CHANGE;
        end else begin
          state_nxt_s = ST_VEND;
        end
      end
      ST_CHANGE: begin
        if (bus.chg_ack) begin
          acc_op_s    = ACC_CLEAR;
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_CHANGE;
        end
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // State, latched data and registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r      <= ST_IDLE;
      lk_code_r    <= {CODE_W{1'b0}};
      chg_amount_r <= {AMT_W{1'b0}};
      price_r      <= {AMT_W{1'b0}};
      vend_cnt_r   <= 16'd0;
      lk_req_r     <= 1'b0;
      vend_go_r    <= 1'b0;
      chg_valid_r  <= 1'b0;
      busy_r       <= 1'b0;
      err_code_r   <= 1'b0;
      err_jam_r    <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      lk_code_r    <= lk_code_nxt_s;
      chg_amount_r <= chg_amount_nxt_s;
      price_r      <= price_nxt_s;
      vend_cnt_r   <= (state_r == ST_VEND) ? (vend_cnt_r + 16'd1) : 16'd0;
      lk_req_r     <= (state_nxt_s == ST_LOOKUP);
      vend_go_r    <= (state_nxt_s == ST_VEND);
      chg_valid_r  <= (state_nxt_s == ST_CHANGE);
      busy_r       <= (state_nxt_s != ST_IDLE) && (state_nxt_s != ST_PAY);
      err_code_r   <= err_code_nxt_s;
      err_jam_r    <= err_jam_nxt_s;
    end
  end

  assign bus.lk_code     = lk_code_r;
  assign bus.lk_req      = lk_req_r;
  assign bus.coin_reject = coin_reject_s;
  assign bus.vend_go     = vend_go_r;
  assign bus.chg_valid   = chg_valid_r;
  assign bus.chg_amount  = chg_amount_r;
  assign bus.credit      = credit_s;
  assign bus.err_code    = err_code_r;
  assign bus.err_jam     = err_jam_r;
  assign bus.busy        = busy_r;

endmodule
